// File: rtl/lane_rr_arbiter.sv
// Round-robin scheduler merging the two PHY RX lane streams onto one byte port.
// Bounded bursts per grant, registered output stage and per-lane beat counters.
module lane_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        lane_en,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_lane,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  beats0,
    output logic [CNT_W-1:0]  beats1
);

    localparam int BURST_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE0,
        SERVE1
    } state_t;

    state_t             state;
    logic               last_lane;
    logic [BURST_W-1:0] burst_cnt;

    logic req0;
    logic req1;
    logic slot_free;
    logic acc0;
    logic acc1;
    logic burst_last;

    assign req0       = in0_valid & lane_en[0];
    assign req1       = in1_valid & lane_en[1];
    assign slot_free  = ~out_valid | out_ready;
    assign in0_ready  = (state == SERVE0) & lane_en[0] & slot_free;
    assign in1_ready  = (state == SERVE1) & lane_en[1] & slot_free;
    assign acc0       = in0_valid & in0_ready;
    assign acc1       = in1_valid & in1_ready;
    assign burst_last = (burst_cnt == BURST_W'(BURST_MAX - 1));

    // NOTE: every register here uses <= so all updates see pre-edge values,
    // regardless of statement order inside the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_lane <= 1'b1;
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_lane  <= 1'b0;
            beats0    <= '0;
            beats1    <= '0;
        end else begin
            if (acc0) beats0 <= beats0 + CNT_W'(1);
            if (acc1) beats1 <= beats1 + CNT_W'(1);

            // Output register: a new accept always lands, since ready implies slot_free.
            if (acc0 | acc1) begin
                out_valid <= 1'b1;
                out_data  <= acc1 ? in1_data : in0_data;
                out_lane  <= acc1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req0 && (last_lane || !req1)) begin
                        state     <= SERVE0;
                        last_lane <= 1'b0;
                        burst_cnt <= '0;
                    end else if (req1) begin
                        state     <= SERVE1;
                        last_lane <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                SERVE0: begin
                    if ((acc0 && burst_last) || !req0) begin
                        if (req1) begin
                            state     <= SERVE1;
                            last_lane <= 1'b1;
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (acc0) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
                SERVE1: begin
                    if ((acc1 && burst_last) || !req1) begin
                        if (req0) begin
                            state     <= SERVE0;
                            last_lane <= 1'b0;
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (acc1) begin
                        burst_cnt <= burst_cnt + BURST_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Randomised and directed bench for lane_rr_arbiter: per-lane source queues feed a
// scoreboard, an output monitor pops and compares, and directed scenarios check grant order.
module tb_lane_rr_arbiter;

    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 4;
    localparam int CNT_W     = 8;

    typedef struct packed {
        logic              lane;
        logic [DATA_W-1:0] data;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        lane_en;
    logic [DATA_W-1:0] in0_data, in1_data;
    logic              in0_valid, in1_valid;
    logic              in0_ready, in1_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_lane, out_valid, out_ready;
    logic [CNT_W-1:0]  beats0, beats1;

    always #5 clk = ~clk;

    lane_rr_arbiter #(.DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .lane_en(lane_en),
        .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_lane(out_lane), .out_valid(out_valid),
        .out_ready(out_ready), .beats0(beats0), .beats1(beats1)
    );

    beat_t             exp_q[$];
    beat_t             log_b[$];
    int                log_c[$];
    logic [DATA_W-1:0] src0[$], src1[$];
    bit                gate0, gate1, burst_chk;
    int                n_cmp = 0, n_err = 0;
    int                cyc = 0;
    logic [CNT_W-1:0]  mdl_beats0, mdl_beats1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        in0_valid = gate0 && (src0.size() != 0);
        in1_valid = gate1 && (src1.size() != 0);
        in0_data  = (src0.size() != 0) ? src0[0] : '0;
        in1_data  = (src1.size() != 0) ? src1[0] : '0;
    endtask

    // One clock: sample handshakes mid-cycle, retire accepted source beats after the edge.
    task automatic tick();
        logic a0, a1;
        @(negedge clk);
        a0 = in0_valid & in0_ready & !reset;
        a1 = in1_valid & in1_ready & !reset;
        @(posedge clk);
        #1;
        if (a0) void'(src0.pop_front());
        if (a1) void'(src1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        gate0 = 1'b0;
        gate1 = 1'b0;
        src0.delete();
        src1.delete();
        drive();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_ab(input int n);
        for (int k = 0; k < n; k++) begin
            src0.push_back(DATA_W'(8'hA0 + k));
            src1.push_back(DATA_W'(8'hB0 + k));
        end
    endtask

    // Both lanes saturated: groups of BURST_MAX alternate, lane 0 first.
    task automatic check_ab_pattern(input string name, input int s, input int n);
        beat_t e;
        int    avail;
        avail = log_b.size() - s;
        check({name, "_len"}, avail, n);
        for (int i = 0; i < n && i < avail; i++) begin
            e.lane = 1'((i / BURST_MAX) % 2);
            e.data = DATA_W'((e.lane ? 8'hB0 : 8'hA0) + (i / (2 * BURST_MAX)) * BURST_MAX + i % BURST_MAX);
            check({name, "_beat"}, log_b[s+i], e);
        end
    endtask

    // Input-side monitor: protocol rules, counter model, latency, burst bound, scoreboard push.
    initial begin
        logic  pend;
        beat_t pend_b;
        int    run;
        logic  run_lane;
        logic  a0, a1;
        pend = 1'b0; run = 0; run_lane = 1'b0;
        mdl_beats0 = '0; mdl_beats1 = '0;
        forever begin
            @(negedge clk);
            check("beats0", beats0, mdl_beats0);
            check("beats1", beats1, mdl_beats1);
            if (pend) begin
                check("out_latency_valid", out_valid, 1);
                check("out_latency_beat", {out_lane, out_data}, pend_b);
            end
            if (reset) begin
                mdl_beats0 = '0; mdl_beats1 = '0;
                pend = 1'b0; run = 0;
            end else begin
                check("ready_exclusive", in0_ready & in1_ready, 0);
                check("ready0_masked", in0_ready & !lane_en[0], 0);
                check("ready1_masked", in1_ready & !lane_en[1], 0);
                check("ready_slot_busy", (in0_ready | in1_ready) & out_valid & !out_ready, 0);
                a0 = in0_valid & in0_ready;
                a1 = in1_valid & in1_ready;
                pend = a0 | a1;
                if (a0) begin
                    pend_b = '{lane: 1'b0, data: in0_data};
                    mdl_beats0 = mdl_beats0 + CNT_W'(1);
                end
                if (a1) begin
                    pend_b = '{lane: 1'b1, data: in1_data};
                    mdl_beats1 = mdl_beats1 + CNT_W'(1);
                end
                if (pend) begin
                    exp_q.push_back(pend_b);
                    if (run > 0 && run_lane == a1) run++;
                    else begin
                        run = 1;
                        run_lane = a1;
                    end
                    if (burst_chk) check("burst_len_ok", run <= BURST_MAX, 1);
                end else if (!out_valid || out_ready) begin
                    run = 0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every delivered beat, checks hold stability.
    initial begin
        logic  hold;
        beat_t hold_v, b;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("out_hold_valid", out_valid, 1);
                    check("out_hold_beat", {out_lane, out_data}, hold_v);
                end
                if (out_valid && out_ready) begin
                    check("sb_has_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        b = exp_q.pop_front();
                        check("out_beat", {out_lane, out_data}, b);
                    end
                    log_b.push_back('{lane: out_lane, data: out_data});
                    log_c.push_back(cyc);
                end
                hold   = out_valid && !out_ready;
                hold_v = '{lane: out_lane, data: out_data};
            end
        end
    end

    initial begin
        int    s, budget, i0, i1;
        beat_t e;
        reset = 1'b1; lane_en = 2'b11; out_ready = 1'b1;
        gate0 = 1'b0; gate1 = 1'b0; burst_chk = 1'b1;
        drive();
        tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", {out_lane, out_data}, 0);
        check("reset_readys", {in0_ready, in1_ready}, 0);

        // 1: lane 0 alone, one idle bubble after each burst
        do_reset();
        s = log_b.size();
        for (int k = 0; k < 8; k++) src0.push_back(DATA_W'(8'h10 + k));
        gate0 = 1'b1;
        drive();
        repeat (20) tick();
        check("t1_count", log_b.size() - s, 8);
        for (int i = 0; i < 8 && s + i < log_b.size(); i++) begin
            e = '{lane: 1'b0, data: DATA_W'(8'h10 + i)};
            check("t1_beat", log_b[s+i], e);
            if (i > 0) check("t1_spacing", log_c[s+i] - log_c[s+i-1], (i == BURST_MAX) ? 2 : 1);
        end
        check("t1_beats0", beats0, 8);

        // 2: both lanes saturated, alternating bursts with no gaps
        do_reset();
        s = log_b.size();
        fill_ab(16);
        gate0 = 1'b1; gate1 = 1'b1;
        drive();
        repeat (40) tick();
        check_ab_pattern("t2", s, 32);
        for (int i = 1; i < 32 && s + i < log_b.size(); i++)
            check("t2_no_gap", log_c[s+i] - log_c[s+i-1], 1);
        check("t2_beats0", beats0, 16);
        check("t2_beats1", beats1, 16);

        // 3: downstream stall mid-burst
        do_reset();
        s = log_b.size();
        fill_ab(16);
        gate0 = 1'b1; gate1 = 1'b1;
        drive();
        repeat (6) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
        repeat (40) tick();
        check_ab_pattern("t3", s, 32);

        // 4: lane 1 masked, then enabled mid lane-0 burst
        do_reset();
        s = log_b.size();
        lane_en = 2'b01;
        for (int k = 0; k < 6; k++) src0.push_back(DATA_W'(8'h40 + k));
        for (int k = 0; k < 8; k++) src1.push_back(DATA_W'(8'h50 + k));
        gate0 = 1'b1; gate1 = 1'b1;
        drive();
        tick();
        tick();
        check("t4_beats1_masked", beats1, 0);
        lane_en = 2'b11;
        repeat (30) tick();
        check("t4_count", log_b.size() - s, 14);
        i0 = 0; i1 = 0;
        for (int i = 0; i < 14 && s + i < log_b.size(); i++) begin
            e.lane = (i >= 4 && i < 8) || i >= 10;
            if (e.lane) begin
                e.data = DATA_W'(8'h50 + i1);
                i1++;
            end else begin
                e.data = DATA_W'(8'h40 + i0);
                i0++;
            end
            check("t4_beat", log_b[s+i], e);
        end

        // 5: reset while serving lane 1 with an undelivered output beat
        do_reset();
        burst_chk = 1'b0;
        fill_ab(16);
        gate0 = 1'b1; gate1 = 1'b1;
        drive();
        repeat (6) tick();
        check("t5_pre_out_lane", {out_valid, out_lane}, 2'b11);
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        check("t5_out_valid", out_valid, 0);
        check("t5_out_beat", {out_lane, out_data}, 0);
        check("t5_beats", {beats0, beats1}, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        s = log_b.size();
        repeat (10) tick();
        check("t5_got_beat", log_b.size() > s, 1);
        if (log_b.size() > s) check("t5_first_grant", log_b[s], {1'b0, 8'hA4});

        // 6: counter wrap
        do_reset();
        burst_chk = 1'b1;
        for (int k = 0; k < (1 << CNT_W) - 1; k++) src0.push_back(DATA_W'($urandom));
        gate0 = 1'b1;
        drive();
        budget = 2000;
        while (src0.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("t6_drain_bound", src0.size(), 0);
        check("t6_preload", beats0, (1 << CNT_W) - 1);
        src0.push_back(8'h5A);
        drive();
        repeat (6) tick();
        check("t6_wrap", beats0, 0);

        // Random traffic, enables and backpressure
        do_reset();
        burst_chk = 1'b0;
        for (int c = 0; c < 800; c++) begin
            while (src0.size() < 4) src0.push_back(DATA_W'($urandom));
            while (src1.size() < 4) src1.push_back(DATA_W'($urandom));
            gate0 = ($urandom_range(0, 3) != 0);
            gate1 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) lane_en = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            drive();
            tick();
        end
        gate0 = 1'b0; gate1 = 1'b0; out_ready = 1'b1;
        drive();
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("rand_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
